// File: rtl/vec_check_seq.sv
// Test-vector sequencer: reads operand/expected triples from three shared-address
// ROMs, runs each pair through an external engine and counts result mismatches.
module vec_check_seq #(
  parameter int DATA_W  = 64,
  parameter int NUM_VEC = 22,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 6,
  parameter int TMO_W   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              stop_on_fail,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  output logic [CNT_W-1:0]  ap_return,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_first_idx,
  output logic              timeout_flag,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_ce,
  input  logic [DATA_W-1:0] a_q,
  input  logic [DATA_W-1:0] b_q,
  input  logic [DATA_W-1:0] exp_q,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_CALL, S_WAIT, S_CHECK, S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fvld_q, fvld_d;
  logic [ADDR_W-1:0]   fidx_q, fidx_d;
  logic                tflag_q, tflag_d;
  logic                sof_q, sof_d;
  logic [DATA_W-1:0]   a_r_q, a_r_d;
  logic [DATA_W-1:0]   b_r_q, b_r_d;
  logic [DATA_W-1:0]   exp_r_q, exp_r_d;
  logic [DATA_W-1:0]   res_r_q, res_r_d;
  logic [TMO_W-1:0]    wd_q, wd_d;
  logic                tmo_q, tmo_d;
  logic                mism;

  // A timed-out call counts as a mismatch regardless of the stale res_r.
  assign mism = (res_r_q != exp_r_q) || tmo_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fvld_d  = fvld_q;
    fidx_d  = fidx_q;
    tflag_d = tflag_q;
    sof_d   = sof_q;
    a_r_d   = a_r_q;
    b_r_d   = b_r_q;
    exp_r_d = exp_r_q;
    res_r_d = res_r_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          idx_d   = '0;
          cnt_d   = '0;
          fvld_d  = 1'b0;
          fidx_d  = '0;
          tflag_d = 1'b0;
          sof_d   = stop_on_fail;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        a_r_d   = a_q;
        b_r_d   = b_q;
        exp_r_d = exp_q;
        state_d = S_CALL;
      end
      S_CALL: begin
        wd_d    = '0;
        tmo_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          res_r_d = eng_result;
          state_d = S_CHECK;
        end else if (wd_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          tflag_d = 1'b1;
          state_d = S_CHECK;
        end else begin
          wd_d = wd_q + TMO_W'(1);
        end
      end
      S_CHECK: begin
        if (mism) begin
          cnt_d = sat_inc(cnt_q);
          if (!fvld_q) begin
            fvld_d = 1'b1;
            fidx_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX || (mism && sof_q)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      fvld_q  <= 1'b0;
      fidx_q  <= '0;
      tflag_q <= 1'b0;
      sof_q   <= 1'b0;
      a_r_q   <= '0;
      b_r_q   <= '0;
      exp_r_q <= '0;
      res_r_q <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fvld_q  <= fvld_d;
      fidx_q  <= fidx_d;
      tflag_q <= tflag_d;
      sof_q   <= sof_d;
      a_r_q   <= a_r_d;
      b_r_q   <= b_r_d;
      exp_r_q <= exp_r_d;
      res_r_q <= res_r_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ap_done        = (state_q == S_DONE);
  assign ap_ready       = (state_q == S_DONE);
  assign ap_idle        = (state_q == S_IDLE) && !ap_start;
  assign ap_return      = cnt_q;
  assign fail_valid     = fvld_q;
  assign fail_first_idx = fidx_q;
  assign timeout_flag   = tflag_q;
  assign vec_addr       = idx_q;
  assign vec_ce         = (state_q == S_FETCH);
  assign eng_start      = (state_q == S_CALL);
  assign eng_a          = a_r_q;
  assign eng_b          = b_r_q;

endmodule

// File: tb/tb_vec_check_seq.sv
// Randomized bench for vec_check_seq: ROMs and engine modelled in the bench,
// expected run results derived from the vector tables by a simple run model.
module tb_vec_check_seq;

  localparam int NV   = 22;
  localparam int TMO  = 16;
  localparam int CMAX = 7;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        stop_on_fail;
  logic        ap_done, ap_ready, ap_idle;
  logic [2:0]  ap_return;
  logic        fail_valid;
  logic [4:0]  fail_first_idx;
  logic        timeout_flag;
  logic [4:0]  vec_addr;
  logic        vec_ce;
  logic [63:0] a_q, b_q, exp_q;
  logic        eng_start;
  logic [63:0] eng_a, eng_b;
  logic        eng_done;
  logic [63:0] eng_result;

  vec_check_seq #(
    .DATA_W(64), .NUM_VEC(NV), .ADDR_W(5), .CNT_W(3), .TMO_W(10), .TIMEOUT(TMO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .stop_on_fail(stop_on_fail),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_return(ap_return),
    .fail_valid(fail_valid), .fail_first_idx(fail_first_idx), .timeout_flag(timeout_flag),
    .vec_addr(vec_addr), .vec_ce(vec_ce), .a_q(a_q), .b_q(b_q), .exp_q(exp_q),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done),
    .eng_result(eng_result)
  );

  always #5 ap_clk = ~ap_clk;

  logic [63:0] rom_a [32];
  logic [63:0] rom_b [32];
  logic [63:0] rom_e [32];
  int          lat   [32];
  bit          silent[32];
  int          cur_vec = 0;
  int          max_addr = -1;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
  endtask

  // Synchronous ROMs sharing one address.
  always @(posedge ap_clk) begin
    if (vec_ce) begin
      a_q   <= rom_a[vec_addr];
      b_q   <= rom_b[vec_addr];
      exp_q <= rom_e[vec_addr];
    end
  end

  initial begin
    forever begin
      @(negedge ap_clk);
      if (vec_ce === 1'b1) begin
        cur_vec = int'(vec_addr);
        if (cur_vec > max_addr) max_addr = cur_vec;
      end
    end
  end

  // Engine: result a+b after lat[] cycles; silent vectors answer only after the timeout.
  initial begin
    eng_done = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n === 1'b1 && eng_start === 1'b1) begin
        int v;
        v = cur_vec;
        check_eq("eng_a", eng_a, rom_a[v]);
        check_eq("eng_b", eng_b, rom_b[v]);
        if (silent[v]) begin
          repeat (TMO + 2) @(posedge ap_clk);
          #1 eng_done = 1'b1; eng_result = rom_e[v];
        end else begin
          repeat (lat[v]) @(posedge ap_clk);
          #1 eng_done = 1'b1; eng_result = rom_a[v] + rom_b[v];
        end
        @(posedge ap_clk);
        #1 eng_done = 1'b0; eng_result = {$urandom, $urandom};
      end
    end
  end

  task automatic fill_tables(input int lmin, input int lmax);
    for (int i = 0; i < 32; i++) begin
      rom_a[i]  = {$urandom, $urandom};
      rom_b[i]  = {$urandom, $urandom};
      rom_e[i]  = rom_a[i] + rom_b[i];
      lat[i]    = $urandom_range(lmax, lmin);
      silent[i] = 1'b0;
    end
  endtask

  task automatic corrupt(input int i);
    rom_e[i] = rom_e[i] ^ (64'd1 << $urandom_range(63, 0));
  endtask

  task automatic model(input bit sof, output int ret, output int first, output bit fv,
                       output bit tf, output int done_cyc, output int last);
    int cyc;
    ret = 0; first = 0; fv = 0; tf = 0; cyc = 0; last = 0;
    for (int i = 0; i < NV; i++) begin
      bit bad;
      bad  = silent[i] || (rom_e[i] != rom_a[i] + rom_b[i]);
      cyc += 4 + (silent[i] ? TMO : lat[i]);
      last = i;
      if (silent[i]) tf = 1;
      if (bad) begin
        if (ret < CMAX) ret++;
        if (!fv) begin fv = 1; first = i; end
        if (sof) break;
      end
    end
    done_cyc = 1 + cyc;
  endtask

  task automatic do_run(input string tag, input bit sof);
    int e_ret, e_first, e_cyc, e_last, done_cyc;
    bit e_fv, e_tf;
    model(sof, e_ret, e_first, e_fv, e_tf, e_cyc, e_last);
    max_addr = -1;
    @(negedge ap_clk);
    ap_start = 1'b1;
    stop_on_fail = sof;
    #1 check_eq({tag, ".idle_start"}, ap_idle, 1'b0);
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    stop_on_fail = ~sof;
    done_cyc = -1;
    for (int c = 1; c < 3000; c++) begin
      @(negedge ap_clk);
      if (ap_done === 1'b1) begin done_cyc = c; break; end
    end
    check_eq({tag, ".done_cyc"}, 64'(done_cyc), 64'(e_cyc));
    check_eq({tag, ".ready"}, ap_ready, 1'b1);
    check_eq({tag, ".ret"}, ap_return, 64'(e_ret));
    check_eq({tag, ".fvalid"}, fail_valid, e_fv);
    check_eq({tag, ".fidx"}, fail_first_idx, 64'(e_first));
    check_eq({tag, ".tflag"}, timeout_flag, e_tf);
    check_eq({tag, ".last_addr"}, 64'(max_addr), 64'(e_last));
    @(negedge ap_clk);
    check_eq({tag, ".done_low"}, ap_done, 1'b0);
    check_eq({tag, ".idle"}, ap_idle, 1'b1);
    check_eq({tag, ".ret_hold"}, ap_return, 64'(e_ret));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".done"}, {ap_done, ap_ready}, 2'b00);
    check_eq({tag, ".ret"}, ap_return, 3'd0);
    check_eq({tag, ".fail"}, {fail_valid, fail_first_idx, timeout_flag}, 7'd0);
    check_eq({tag, ".rom"}, {vec_addr, vec_ce}, 6'd0);
    check_eq({tag, ".estart"}, eng_start, 1'b0);
    check_eq({tag, ".eng_a"}, eng_a, 64'd0);
    check_eq({tag, ".eng_b"}, eng_b, 64'd0);
    check_eq({tag, ".idle"}, ap_idle, 1'b1);
  endtask

  initial begin
    bit found;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    stop_on_fail = 1'b0;
    fill_tables(1, 1);
    repeat (3) @(posedge ap_clk);
    #1 check_zero("reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    fill_tables(1, 1);
    do_run("all_match", 1'b0);

    fill_tables(3, 3);
    corrupt(3); corrupt(17);
    do_run("two_mism", 1'b0);

    fill_tables(1, 1);
    corrupt(5); corrupt(9);
    do_run("stop_fail", 1'b1);

    fill_tables(1, 1);
    silent[7] = 1'b1;
    do_run("timeout", 1'b0);

    fill_tables(1, 1);
    for (int i = 0; i < NV; i++) corrupt(i);
    do_run("saturate", 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_tables(1, 6);
      for (int i = 0; i < NV; i++) begin
        if ($urandom_range(99, 0) < 15) corrupt(i);
        if ($urandom_range(99, 0) < 5) silent[i] = 1'b1;
      end
      do_run($sformatf("rand%0d", r), 1'($urandom_range(1, 0)));
    end

    // Reset while waiting on vector 9's engine call.
    fill_tables(3, 3);
    corrupt(2);
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1 ap_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge ap_clk);
      if (eng_start === 1'b1 && cur_vec == 9) begin found = 1'b1; break; end
    end
    check_eq("rst_mid.reach_v9", found, 1'b1);
    @(posedge ap_clk);
    #2 check_eq("rst_mid.pre_fvalid", fail_valid, 1'b1);
    ap_rst_n = 1'b0;
    #1 check_zero("rst_mid");
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (20) @(negedge ap_clk);
    fill_tables(1, 1);
    do_run("after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
